// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - button/UART command merge, mode routing and byte acknowledge for watch_stopwatch
module uart_cmd_ctrl #(
  parameter bit ECHO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_btn,
  input  logic [1:0] i_sw,
  input  logic       i_is_running,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_tx_busy,
  output logic       o_sec_plus,
  output logic       o_min_plus,
  output logic       o_hour_plus,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic [1:0] o_mode_sel,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start
);

  typedef enum logic [1:0] {IDLE, WAIT, START, HOLD} tx_state_t;

  tx_state_t   state, state_next;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [1:0]  tgl;
  logic        sw_mode;
  logic [7:0]  cmd_char;
  logic        uart_issue;
  logic        uart_ok;
  logic        resp_load;
  logic        cmd_sec, cmd_min, cmd_hour, cmd_run, cmd_stop, cmd_clear;
  logic        cmd_tgl_m, cmd_tgl_f;

  assign o_mode_sel = i_sw ^ tgl;
  assign sw_mode    = o_mode_sel[1];
  assign cmd_char   = pend_data & 8'hDF;
  assign uart_issue = pend_valid && (i_btn == 3'b000);
  assign resp_load  = ECHO_EN && uart_issue && (state == IDLE);

  // Buttons own the issue slot; the pending UART byte waits for a button-free cycle.
  always_comb begin
    cmd_sec   = 1'b0;
    cmd_min   = 1'b0;
    cmd_hour  = 1'b0;
    cmd_run   = 1'b0;
    cmd_stop  = 1'b0;
    cmd_clear = 1'b0;
    cmd_tgl_m = 1'b0;
    cmd_tgl_f = 1'b0;
    uart_ok   = 1'b0;
    if (i_btn[0]) begin
      if (!sw_mode)          cmd_sec  = 1'b1;
      else if (i_is_running) cmd_stop = 1'b1;
      else                   cmd_run  = 1'b1;
    end else if (i_btn[1]) begin
      if (!sw_mode) cmd_min   = 1'b1;
      else          cmd_clear = 1'b1;
    end else if (i_btn[2]) begin
      if (!sw_mode) cmd_hour = 1'b1;
    end else if (pend_valid) begin
      case (cmd_char)
        8'h53: if (!sw_mode) begin cmd_sec  = 1'b1; uart_ok = 1'b1; end
        8'h4E: if (!sw_mode) begin cmd_min  = 1'b1; uart_ok = 1'b1; end
        8'h48: if (!sw_mode) begin cmd_hour = 1'b1; uart_ok = 1'b1; end
        8'h52: if (sw_mode) begin
          cmd_run  = !i_is_running;
          cmd_stop = i_is_running;
          uart_ok  = 1'b1;
        end
        8'h43: if (sw_mode) begin cmd_clear = 1'b1; uart_ok = 1'b1; end
        8'h4D: begin cmd_tgl_m = 1'b1; uart_ok = 1'b1; end
        8'h46: begin cmd_tgl_f = 1'b1; uart_ok = 1'b1; end
        default: uart_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sec_plus  <= 1'b0;
      o_min_plus  <= 1'b0;
      o_hour_plus <= 1'b0;
      o_run       <= 1'b0;
      o_stop      <= 1'b0;
      o_clear     <= 1'b0;
      tgl         <= 2'b00;
      pend_valid  <= 1'b0;
      pend_data   <= 8'h00;
      o_tx_data   <= 8'h00;
    end else begin
      o_sec_plus  <= cmd_sec;
      o_min_plus  <= cmd_min;
      o_hour_plus <= cmd_hour;
      o_run       <= cmd_run;
      o_stop      <= cmd_stop;
      o_clear     <= cmd_clear;
      if (cmd_tgl_m) tgl[1] <= ~tgl[1];
      if (cmd_tgl_f) tgl[0] <= ~tgl[0];
      // A byte arriving while the entry is occupied (even in its issue cycle) is lost.
      if (uart_issue) begin
        pend_valid <= 1'b0;
      end else if (i_rx_done && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= i_rx_data;
      end
      if (resp_load) o_tx_data <= uart_ok ? pend_data : 8'h3F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_tx_start = 1'b0;
    case (state)
      IDLE:  if (resp_load) state_next = WAIT;
      WAIT:  if (!i_tx_busy) state_next = START;
      START: begin
        o_tx_start = 1'b1;
        state_next = HOLD;
      end
      HOLD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed-vector bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] i_btn;
  logic [1:0] i_sw;
  logic       i_is_running;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_busy;
  logic       o_sec_plus, o_min_plus, o_hour_plus, o_run, o_stop, o_clear;
  logic [1:0] o_mode_sel;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] p_obs, st_obs, txd_obs, mode_obs, st_cnt;

  localparam logic [7:0] P_NONE = 8'b00_000000;
  localparam logic [7:0] P_SEC  = 8'b00_100000;
  localparam logic [7:0] P_MIN  = 8'b00_010000;
  localparam logic [7:0] P_RUN  = 8'b00_000100;
  localparam logic [7:0] P_STOP = 8'b00_000010;
  localparam logic [7:0] P_CLR  = 8'b00_000001;

  always #5 clk = ~clk;

  uart_cmd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_btn        (i_btn),
    .i_sw         (i_sw),
    .i_is_running (i_is_running),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_busy    (i_tx_busy),
    .o_sec_plus   (o_sec_plus),
    .o_min_plus   (o_min_plus),
    .o_hour_plus  (o_hour_plus),
    .o_run        (o_run),
    .o_stop       (o_stop),
    .o_clear      (o_clear),
    .o_mode_sel   (o_mode_sel),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sample outputs mid-cycle, advance to just after the next edge.
  task automatic cyc(input logic [2:0] btn, input logic rxd, input logic [7:0] rxb);
    i_btn     = btn;
    i_rx_done = rxd;
    i_rx_data = rxb;
    @(negedge clk);
    p_obs    = {2'b00, o_sec_plus, o_min_plus, o_hour_plus, o_run, o_stop, o_clear};
    st_obs   = {7'd0, o_tx_start};
    txd_obs  = o_tx_data;
    mode_obs = {6'd0, o_mode_sel};
    @(posedge clk);
    #1;
    i_btn     = 3'b000;
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(3'b000, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; i_btn = 3'b000; i_sw = 2'b01; i_is_running = 1'b0;
    i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_busy = 1'b0;

    cyc(3'b000, 1'b0, 8'h00);
    chk("rst_pulses", p_obs, P_NONE);
    chk("rst_start", st_obs, 8'd0);
    chk("rst_txd", txd_obs, 8'h00);
    chk("rst_mode", mode_obs, 8'd1);
    i_sw = 2'b00;
    rst  = 1'b0;
    idle(1);

    // watch-mode buttons
    cyc(3'b001, 1'b0, 8'h00); chk("btnA_same_cycle", p_obs, P_NONE);
    cyc(3'b000, 1'b0, 8'h00); chk("btnA_sec", p_obs, P_SEC);
    cyc(3'b000, 1'b0, 8'h00); chk("btnA_one_cycle", p_obs, P_NONE);
    cyc(3'b110, 1'b0, 8'h00);
    cyc(3'b000, 1'b0, 8'h00); chk("btnBC_min_only", p_obs, P_MIN);

    // stopwatch, 'r' while stopped
    i_sw = 2'b10;
    cyc(3'b000, 1'b1, 8'h72);
    cyc(3'b000, 1'b0, 8'h00); chk("r_n1_quiet", p_obs, P_NONE);
    cyc(3'b000, 1'b0, 8'h00);
    chk("r_run", p_obs, P_RUN);
    chk("r_echo", txd_obs, 8'h72);
    chk("r_no_start_yet", st_obs, 8'd0);
    cyc(3'b000, 1'b0, 8'h00); chk("r_start", st_obs, 8'd1);
    cyc(3'b000, 1'b0, 8'h00); chk("r_start_once", st_obs, 8'd0);
    idle(2);

    // 'R' while running
    i_is_running = 1'b1;
    cyc(3'b000, 1'b1, 8'h52);
    idle(1);
    cyc(3'b000, 1'b0, 8'h00);
    chk("R_stop", p_obs, P_STOP);
    chk("R_echo", txd_obs, 8'h52);
    cyc(3'b000, 1'b0, 8'h00); chk("R_start", st_obs, 8'd1);
    idle(3);
    i_is_running = 1'b0;

    // watch mode: 'C' rejected, then mode toggles
    i_sw = 2'b00;
    cyc(3'b000, 1'b1, 8'h43);
    idle(1);
    cyc(3'b000, 1'b0, 8'h00);
    chk("C_no_pulse", p_obs, P_NONE);
    chk("C_reject_resp", txd_obs, 8'h3F);
    cyc(3'b000, 1'b0, 8'h00); chk("C_start", st_obs, 8'd1);
    idle(3);

    cyc(3'b000, 1'b1, 8'h6D);
    cyc(3'b000, 1'b0, 8'h00); chk("m_mode_before", mode_obs, 8'd0);
    cyc(3'b000, 1'b0, 8'h00);
    chk("m_mode_after", mode_obs, 8'd2);
    chk("m_echo", txd_obs, 8'h6D);
    idle(4);

    cyc(3'b000, 1'b1, 8'h46);
    idle(1);
    cyc(3'b000, 1'b0, 8'h00); chk("F_mode", mode_obs, 8'd3);
    idle(4);

    i_sw = 2'b10;
    cyc(3'b000, 1'b0, 8'h00); chk("sw_xor_tgl", mode_obs, 8'd1);

    // 'S' delayed by two button cycles; 'H' arriving while pending is dropped
    cyc(3'b000, 1'b1, 8'h53);
    cyc(3'b010, 1'b1, 8'h48); chk("col_n1", p_obs, P_NONE);
    cyc(3'b010, 1'b0, 8'h00); chk("col_n2_min", p_obs, P_MIN);
    cyc(3'b000, 1'b0, 8'h00); chk("col_n3_min", p_obs, P_MIN);
    cyc(3'b000, 1'b0, 8'h00);
    chk("col_n4_sec", p_obs, P_SEC);
    chk("col_echo", txd_obs, 8'h53);
    cyc(3'b000, 1'b0, 8'h00);
    chk("col_start", st_obs, 8'd1);
    chk("col_n5_quiet", p_obs, P_NONE);
    cyc(3'b000, 1'b0, 8'h00); chk("col_drop", p_obs, P_NONE);
    idle(3);

    // transmitter busy holds the FSM in WAIT
    i_sw = 2'b00;
    i_tx_busy = 1'b1;
    cyc(3'b000, 1'b1, 8'h72);
    idle(1);
    cyc(3'b000, 1'b0, 8'h00); chk("busy_run", p_obs, P_RUN);
    st_cnt = 8'd0;
    for (int i = 0; i < 50; i++) begin
      cyc(3'b000, 1'b0, 8'h00);
      st_cnt = st_cnt + st_obs;
    end
    chk("busy_no_start", st_cnt, 8'd0);
    i_tx_busy = 1'b0;
    cyc(3'b000, 1'b0, 8'h00); chk("busy_fall_wait", st_obs, 8'd0);
    cyc(3'b000, 1'b0, 8'h00); chk("busy_fall_start", st_obs, 8'd1);
    i_tx_busy = 1'b1;
    idle(2);
    i_tx_busy = 1'b0;
    idle(2);

    // reset while waiting on the transmitter
    i_tx_busy = 1'b1;
    cyc(3'b000, 1'b1, 8'h63);
    idle(1);
    cyc(3'b000, 1'b0, 8'h00); chk("c_clear", p_obs, P_CLR);
    rst = 1'b1;
    cyc(3'b000, 1'b0, 8'h00);
    chk("rst2_pulses", p_obs, P_NONE);
    chk("rst2_start", st_obs, 8'd0);
    chk("rst2_txd", txd_obs, 8'h00);
    chk("rst2_mode", mode_obs, 8'd0);
    rst = 1'b0;
    i_tx_busy = 1'b0;
    st_cnt = 8'd0;
    for (int i = 0; i < 10; i++) begin
      cyc(3'b000, 1'b0, 8'h00);
      st_cnt = st_cnt + st_obs;
    end
    chk("rst2_no_start", st_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller between the board inputs, the UART receiver/transmitter and `watch_stopwatch`. It merges debounced button pulses and ASCII commands from UART into single-cycle control pulses, and routes them by the current display mode. It owns the mode-toggle state that the UART can flip on top of the slide switches. It acknowledges every received byte through the UART transmitter.

## Interface
- `ECHO_EN`, default 1: 1 enables the response transmitter; 0 keeps `o_tx_start` at 0.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_btn`  in  3  debounced one-cycle pulses: [0]=A, [1]=B, [2]=C.
- `i_sw`  in  2  slide switches: [1]=watch(0)/stopwatch(1), [0]=fnd mode.
- `i_is_running`  in  1  stopwatch running flag.
- `i_rx_data`  in  8  received byte, valid when `i_rx_done`=1.
- `i_rx_done`  in  1  one-cycle receive strobe.
- `i_tx_busy`  in  1  transmitter busy.
- `o_sec_plus`, `o_min_plus`, `o_hour_plus`  out  1 each  watch adjust pulses.
- `o_run`, `o_stop`, `o_clear`  out  1 each  stopwatch control pulses.
- `o_mode_sel`  out  2  equals `i_sw ^ tgl`, where `tgl` is a 2-bit internal register.
- `o_tx_data`  out  8  response byte.
- `o_tx_start`  out  1  one-cycle transmit request.

## Operation
- Command decode:
  - Letters are case-insensitive (bit 5 masked).
  - `S`: sec+. `N`: min+. `H`: hour+. These apply only in watch mode.
  - `R`: run if `i_is_running`=0, else stop. `C`: clear. These apply only in stopwatch mode.
  - `M` toggles `tgl[1]`. `F` toggles `tgl[0]`. These apply in any mode.
  - Any other byte, or a command that does not apply to the current mode, is rejected. A rejected byte produces no pulse.
- Buttons:
  - Watch mode: A=sec+, B=min+, C=hour+.
  - Stopwatch mode: A=run/stop (same rule as `R`), B=clear, C ignored.
  - If more than one button bit is set, only the lowest set bit is used.
- Pending buffer: one entry. `i_rx_done` loads it only when it is empty. A byte that arrives while the entry is full is dropped, with no response.
- Issue slot: one command per cycle.
  - A button pulse wins over the pending UART command.
  - The pending command issues in the first cycle with `i_btn`=0. The entry is then cleared.
  - Mode routing and `i_is_running` are sampled in the issue cycle, using the current `o_mode_sel[1]`.
- `o_mode_sel` is combinational from `i_sw` and `tgl`. A switch change takes effect immediately and does not clear `tgl`.
- Responses (UART commands only):
  - Executed command: echo the original byte. Rejected byte: `?` (0x3F).
  - One response register. If it is still occupied when a new response is needed, the new response is dropped. The command itself still executes.
- Transmit FSM:
  - IDLE → WAIT when a response is loaded.
  - WAIT → START when `i_tx_busy`=0.
  - START (`o_tx_start`=1 for one cycle) → HOLD.
  - HOLD (one cycle) → IDLE, and the response register is freed.
  - The UART transmitter raises `i_tx_busy` within one cycle of start.

## Timing
- Reset values: all pulse outputs 0, `o_tx_start` 0, `o_tx_data` 0x00, `tgl` 00 (so `o_mode_sel` = `i_sw`), pending buffer empty, FSM in IDLE.
- Reset mid-transmission aborts the FSM to IDLE. The pending byte and the response are discarded.
- All pulse outputs are registered. Exactly one cycle high; at most one of the six is high per cycle.
- Button pulse in cycle n → output pulse in cycle n+1.
- `i_rx_done` in cycle n with no button in n+1 → pulse (or `tgl` change) visible in cycle n+2. The response is loaded in the same edge.
- Each cycle with a button pulse delays the pending command by one cycle.
- Response loaded in cycle k with `i_tx_busy`=0 → `o_tx_start`=1 in cycle k+2. `o_tx_data` is stable from k+1 until the FSM returns to IDLE.

## Test plan
- Watch mode (`i_sw`=00), `i_btn`=001 for one cycle → `o_sec_plus` high exactly in the next cycle. `i_btn`=110 → only `o_min_plus`.
- Stopwatch mode, `i_is_running`=0, rx `r` → `o_run` pulse at n+2 and `o_tx_data`=0x72 with one `o_tx_start`. Repeat with `i_is_running`=1 → `o_stop`.
- Watch mode, rx `C` → no pulse, response 0x3F. Rx `m` → `o_mode_sel` goes 00→10 at n+2. Rx `F` → 11. Set `i_sw`=10 → `o_mode_sel`=01.
- Rx `S` in cycle n with `i_btn`=010 in n+1 and n+2 → `o_min_plus` in n+2 and n+3, `o_sec_plus` in n+4. A second rx in n+1 is dropped.
- `i_tx_busy` held 1 for 50 cycles after an `R` command → `o_tx_start` fires 2 cycles after busy falls. Assert `rst` in WAIT → all outputs 0 and no later start.
